// File: rtl/apb_demux_top.sv
`default_nettype none
// ============================================================================
// Module      : apb_demux_top
// Description : 1:N APB decoder. One upstream requester is routed to one of
//               NUM_APB_SLAVES completers selected by PADDR[SEL_LSB+:SEL_WIDTH].
//               Request path is registered; unmapped indices and completers
//               that never assert PREADY are answered with PSLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_demux_top #(
    parameter int NUM_APB_SLAVES = 9,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_STRB_WIDTH = 4,
    parameter int SEL_LSB        = 28,
    parameter int SEL_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                     PCLK,
    input  logic                                     PRESET,
    // upstream requester side
    input  logic                                     PSEL_s,
    input  logic                                     PENABLE_s,
    input  logic [APB_ADDR_WIDTH-1:0]                PADDR_s,
    input  logic                                     PWRITE_s,
    input  logic [APB_DATA_WIDTH-1:0]                PWDATA_s,
    input  logic [APB_STRB_WIDTH-1:0]                PSTRB_s,
    input  logic [2:0]                               PPROT_s,
    output logic [APB_DATA_WIDTH-1:0]                PRDATA_s,
    output logic                                     PREADY_s,
    output logic                                     PSLVERR_s,
    // downstream completer side
    output logic [NUM_APB_SLAVES-1:0]                PSEL_m,
    output logic                                     PENABLE_m,
    output logic [APB_ADDR_WIDTH-1:0]                PADDR_m,
    output logic                                     PWRITE_m,
    output logic [APB_DATA_WIDTH-1:0]                PWDATA_m,
    output logic [APB_STRB_WIDTH-1:0]                PSTRB_m,
    output logic [2:0]                               PPROT_m,
    input  logic [NUM_APB_SLAVES*APB_DATA_WIDTH-1:0] PRDATA_m,
    input  logic [NUM_APB_SLAVES-1:0]                PREADY_m,
    input  logic [NUM_APB_SLAVES-1:0]                PSLVERR_m
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_M_SETUP  = 3'd1,
        S_M_ACCESS = 3'd2,
        S_DECERR   = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t                      r_state_q,   w_state_d;
    logic [c_CNT_W-1:0]          r_cnt_q,     w_cnt_d;
    logic [NUM_APB_SLAVES-1:0]   r_psel_q,    w_psel_d;
    logic                        r_penable_q, w_penable_d;
    logic [APB_ADDR_WIDTH-1:0]   r_paddr_q,   w_paddr_d;
    logic                        r_pwrite_q,  w_pwrite_d;
    logic [APB_DATA_WIDTH-1:0]   r_pwdata_q,  w_pwdata_d;
    logic [APB_STRB_WIDTH-1:0]   r_pstrb_q,   w_pstrb_d;
    logic [2:0]                  r_pprot_q,   w_pprot_d;
    logic [APB_DATA_WIDTH-1:0]   r_prdata_q,  w_prdata_d;
    logic                        r_pready_q,  w_pready_d;
    logic                        r_pslverr_q, w_pslverr_d;

    logic [SEL_WIDTH-1:0]        w_idx;
    logic [NUM_APB_SLAVES-1:0]   w_dec;
    logic [APB_DATA_WIDTH-1:0]   w_sel_rdata;
    logic                        w_sel_ready;
    logic                        w_sel_err;

    assign w_idx = PADDR_s[SEL_LSB +: SEL_WIDTH];

    // Address decode: one-hot slave select, all-zero when the index is unmapped
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_APB_SLAVES; i++) begin
            w_dec[i] = (w_idx == SEL_WIDTH'(i));
        end
    end

    // Response mux: only the slave currently holding PSEL_m contributes
    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        for (int i = 0; i < NUM_APB_SLAVES; i++) begin
            if (r_psel_q[i]) begin
                w_sel_rdata = w_sel_rdata | PRDATA_m[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                w_sel_ready = w_sel_ready | PREADY_m[i];
                w_sel_err   = w_sel_err   | PSLVERR_m[i];
            end
        end
    end

    // Next-state and registered-output computation for the transfer FSM
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_psel_d    = r_psel_q;
        w_penable_d = r_penable_q;
        w_paddr_d   = r_paddr_q;
        w_pwrite_d  = r_pwrite_q;
        w_pwdata_d  = r_pwdata_q;
        w_pstrb_d   = r_pstrb_q;
        w_pprot_d   = r_pprot_q;
        w_prdata_d  = r_prdata_q;
        w_pready_d  = 1'b0;
        w_pslverr_d = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                // only a genuine SETUP phase starts a transfer; a lingering
                // ACCESS phase from the previous transfer is ignored
                if (PSEL_s && !PENABLE_s) begin
                    w_paddr_d  = PADDR_s;
                    w_pwrite_d = PWRITE_s;
                    w_pwdata_d = PWDATA_s;
                    w_pstrb_d  = PSTRB_s;
                    w_pprot_d  = PPROT_s;
                    if (|w_dec) begin
                        w_psel_d  = w_dec;
                        w_state_d = S_M_SETUP;
                    end else begin
                        w_state_d = S_DECERR;
                    end
                end
            end

            S_M_SETUP: begin
                w_penable_d = 1'b1;
                w_state_d   = S_M_ACCESS;
            end

            S_M_ACCESS: begin
                w_cnt_d = r_cnt_q + c_CNT_ONE;
                // a ready in the last allowed cycle still completes normally
                if (w_sel_ready) begin
                    w_psel_d    = '0;
                    w_penable_d = 1'b0;
                    w_prdata_d  = r_pwrite_q ? '0 : w_sel_rdata;
                    w_pslverr_d = w_sel_err;
                    w_pready_d  = 1'b1;
                    w_state_d   = S_RESP;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_psel_d    = '0;
                    w_penable_d = 1'b0;
                    w_prdata_d  = '0;
                    w_pslverr_d = 1'b1;
                    w_pready_d  = 1'b1;
                    w_state_d   = S_RESP;
                end
            end

            S_DECERR: begin
                w_prdata_d  = '0;
                w_pslverr_d = 1'b1;
                w_pready_d  = 1'b1;
                w_state_d   = S_RESP;
            end

            S_RESP: begin
                w_cnt_d   = '0;
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_psel_q    <= '0;
            r_penable_q <= 1'b0;
            r_paddr_q   <= '0;
            r_pwrite_q  <= 1'b0;
            r_pwdata_q  <= '0;
            r_pstrb_q   <= '0;
            r_pprot_q   <= '0;
            r_prdata_q  <= '0;
            r_pready_q  <= 1'b0;
            r_pslverr_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_psel_q    <= w_psel_d;
            r_penable_q <= w_penable_d;
            r_paddr_q   <= w_paddr_d;
            r_pwrite_q  <= w_pwrite_d;
            r_pwdata_q  <= w_pwdata_d;
            r_pstrb_q   <= w_pstrb_d;
            r_pprot_q   <= w_pprot_d;
            r_prdata_q  <= w_prdata_d;
            r_pready_q  <= w_pready_d;
            r_pslverr_q <= w_pslverr_d;
        end
    end

    assign PSEL_m    = r_psel_q;
    assign PENABLE_m = r_penable_q;
    assign PADDR_m   = r_paddr_q;
    assign PWRITE_m  = r_pwrite_q;
    assign PWDATA_m  = r_pwdata_q;
    assign PSTRB_m   = r_pstrb_q;
    assign PPROT_m   = r_pprot_q;
    assign PRDATA_s  = r_prdata_q;
    assign PREADY_s  = r_pready_q;
    assign PSLVERR_s = r_pslverr_q;

endmodule
`default_nettype wire
